// File: rtl/reuleaux_pkg.sv
// Shared types and constants for the Reuleaux-triangle sequencer.
// The FSM state order matters: each ARCn is immediately followed by its GAPn.
package reuleaux_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CALC,
        ARC0,
        GAP0,
        ARC1,
        GAP1,
        ARC2,
        GAP2,
        DONE
    } state_t;

    localparam int SCREEN_W_DEFAULT = 160;
    localparam int SCREEN_H_DEFAULT = 120;

    // sqrt(3)/2 - 1/(2*sqrt(3)) and 1/(2*sqrt(3)) in Q10
    localparam int K_H1    = 591;
    localparam int K_H2    = 296;
    localparam int K_SHIFT = 10;

    typedef logic signed [9:0] coord_t;

    function automatic logic [1:0] arc_index(input state_t s);
        case (s)
            ARC1, GAP1: return 2'd1;
            ARC2, GAP2: return 2'd2;
            default:    return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/reuleaux_window.sv
// Combinational test of whether a pixel lies on the wanted 60-degree arc
// for the currently active vertex.
module reuleaux_window
    import reuleaux_pkg::*;
(
    input  logic [1:0] arc_idx,
    input  coord_t     cx,
    input  coord_t     cy,
    input  coord_t     d,
    input  coord_t     h1,
    input  coord_t     h2,
    input  coord_t     px,
    input  coord_t     py,
    output logic       in_window
);

    coord_t half;
    coord_t top_y;
    coord_t base_y;
    coord_t arc0_hi;

    assign half    = d >>> 1;
    assign top_y   = cy - h1;
    assign base_y  = cy + h2;
    assign arc0_hi = top_y + d;

    always_comb begin
        in_window = 1'b0;
        case (arc_idx)
            2'd0: in_window = (py >= base_y) && (py <= arc0_hi);
            2'd1: in_window = (px >= cx) && (px <= cx + half) &&
                              (py >= top_y) && (py <= base_y);
            2'd2: in_window = (px >= cx - half) && (px <= cx) &&
                              (py >= top_y) && (py <= base_y);
            default: in_window = 1'b0;
        endcase
    end

endmodule

// File: rtl/reuleaux_seq.sv
// Reuleaux-triangle sequencer: computes the three vertices, drives the shared
// arc engine once per vertex and gates its pixel stream to the wanted arcs.
module reuleaux_seq
    import reuleaux_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEFAULT,
    parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [7:0] centre_y,
    input  logic [7:0] diameter,
    output logic       done,
    output logic [7:0] arc_centre_x,
    output logic [7:0] arc_centre_y,
    output logic [7:0] arc_radius,
    output logic       arc_start,
    input  logic       arc_finished,
    input  logic [7:0] arc_x,
    input  logic [6:0] arc_y,
    input  logic       arc_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam logic [17:0] H1_MUL = 18'(K_H1);
    localparam logic [17:0] H2_MUL = 18'(K_H2);

    state_t     state_reg, state_next;
    logic [2:0] colour_reg;
    logic [7:0] cx_reg, cy_reg, d_reg;
    coord_t     h1_reg, h2_reg;
    coord_t     vtx_x_reg [3];
    coord_t     vtx_y_reg [3];
    logic [7:0] arc_centre_x_reg, arc_centre_y_reg;
    logic       arc_start_reg, done_reg;

    logic       latch_en, calc_en, in_arc, in_window;
    logic       arc_start_next, done_next;
    logic [1:0] arc_idx;
    logic [2:0] skip;

    coord_t     cx_s, cy_s, d_s, half_s, h1_calc, h2_calc, px_s, py_s;
    coord_t     vx_calc [3];
    coord_t     vy_calc [3];

    assign cx_s    = $signed({2'b00, cx_reg});
    assign cy_s    = $signed({2'b00, cy_reg});
    assign d_s     = $signed({2'b00, d_reg});
    assign half_s  = $signed({3'b000, d_reg[7:1]});
    assign h1_calc = $signed({2'b00, 8'(({10'd0, d_reg} * H1_MUL) >> K_SHIFT)});
    assign h2_calc = $signed({2'b00, 8'(({10'd0, d_reg} * H2_MUL) >> K_SHIFT)});
    assign px_s    = $signed({2'b00, arc_x});
    assign py_s    = $signed({3'b000, arc_y});

    // Vertex order matches arc order: top, bottom-left, bottom-right
    assign vx_calc[0] = cx_s;
    assign vy_calc[0] = cy_s - h1_calc;
    assign vx_calc[1] = cx_s - half_s;
    assign vy_calc[1] = cy_s + h2_calc;
    assign vx_calc[2] = cx_s + half_s;
    assign vy_calc[2] = cy_s + h2_calc;

    for (genvar gi = 0; gi < 3; gi++) begin : g_skip
        assign skip[gi] = (vtx_x_reg[gi] < 10'sd0) || (vtx_x_reg[gi] > 10'sd255) ||
                          (vtx_y_reg[gi] < 10'sd0) || (vtx_y_reg[gi] > 10'sd255);
    end

    assign arc_idx = arc_index(state_reg);

    always_comb begin
        state_next     = state_reg;
        arc_start_next = 1'b0;
        done_next      = 1'b0;
        latch_en       = 1'b0;
        calc_en        = 1'b0;
        in_arc         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    latch_en   = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                calc_en    = 1'b1;
                state_next = ARC0;
            end
            // ARCn + 1 is GAPn, and GAPn + 1 is the next ARC (or DONE)
            ARC0, ARC1, ARC2: begin
                in_arc         = 1'b1;
                arc_start_next = !skip[arc_idx];
                if (skip[arc_idx] || arc_finished)
                    state_next = state_t'(state_reg + 4'd1);
            end
            GAP0, GAP1, GAP2: begin
                if (skip[arc_idx] || !arc_finished)
                    state_next = state_t'(state_reg + 4'd1);
            end
            DONE: begin
                done_next = 1'b1;
                if (!start)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (!start && state_reg != IDLE && state_reg != DONE) begin
            state_next     = IDLE;
            arc_start_next = 1'b0;
            done_next      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            arc_start_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            arc_start_reg <= arc_start_next;
            done_reg      <= done_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colour_reg <= '0;
            cx_reg     <= '0;
            cy_reg     <= '0;
            d_reg      <= '0;
        end else if (latch_en) begin
            colour_reg <= colour;
            cx_reg     <= centre_x;
            cy_reg     <= centre_y;
            d_reg      <= diameter;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_reg <= '0;
            h2_reg <= '0;
            for (int i = 0; i < 3; i++) begin
                vtx_x_reg[i] <= '0;
                vtx_y_reg[i] <= '0;
            end
        end else if (calc_en) begin
            h1_reg <= h1_calc;
            h2_reg <= h2_calc;
            for (int i = 0; i < 3; i++) begin
                vtx_x_reg[i] <= vx_calc[i];
                vtx_y_reg[i] <= vy_calc[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arc_centre_x_reg <= '0;
            arc_centre_y_reg <= '0;
        end else if (in_arc && !skip[arc_idx]) begin
            arc_centre_x_reg <= vtx_x_reg[arc_idx][7:0];
            arc_centre_y_reg <= vtx_y_reg[arc_idx][7:0];
        end
    end

    reuleaux_window u_window (
        .arc_idx   (arc_idx),
        .cx        (cx_s),
        .cy        (cy_s),
        .d         (d_s),
        .h1        (h1_reg),
        .h2        (h2_reg),
        .px        (px_s),
        .py        (py_s),
        .in_window (in_window)
    );

    assign done         = done_reg;
    assign arc_start    = arc_start_reg;
    assign arc_centre_x = arc_centre_x_reg;
    assign arc_centre_y = arc_centre_y_reg;
    assign arc_radius   = d_reg;
    assign vga_x        = arc_x;
    assign vga_y        = arc_y;
    assign vga_colour   = colour_reg;
    assign vga_plot     = arc_plot && in_arc && in_window &&
                          (int'(arc_x) < SCREEN_W) && (int'(arc_y) < SCREEN_H);

endmodule

// File: tb/tb_reuleaux_seq.sv
// Self-checking bench for reuleaux_seq: directed scenarios plus randomized
// shapes, checked against a geometric reference model.
module tb_reuleaux_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] colour = '0;
    logic [7:0] centre_x = '0, centre_y = '0, diameter = '0;
    logic       done;
    logic [7:0] arc_centre_x, arc_centre_y, arc_radius;
    logic       arc_start;
    logic       arc_finished = 1'b0;
    logic [7:0] arc_x = '0;
    logic [6:0] arc_y = '0;
    logic       arc_plot = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int err_cnt = 0;
    int chk_cnt = 0;

    typedef struct {
        int arc;
        int x;
        int y;
        bit exp;
    } dir_t;
    dir_t dir_q[$];

    int m_cx, m_cy, m_d, m_h1, m_h2, m_half;
    int m_vx[3];
    int m_vy[3];
    bit m_skip[3];

    always #5 clk = ~clk;

    reuleaux_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .colour       (colour),
        .centre_x     (centre_x),
        .centre_y     (centre_y),
        .diameter     (diameter),
        .done         (done),
        .arc_centre_x (arc_centre_x),
        .arc_centre_y (arc_centre_y),
        .arc_radius   (arc_radius),
        .arc_start    (arc_start),
        .arc_finished (arc_finished),
        .arc_x        (arc_x),
        .arc_y        (arc_y),
        .arc_plot     (arc_plot),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void model_setup(input int cx, input int cy, input int d);
        m_cx   = cx;
        m_cy   = cy;
        m_d    = d;
        m_h1   = (d * 591) / 1024;
        m_h2   = (d * 296) / 1024;
        m_half = d / 2;
        m_vx[0] = cx;          m_vy[0] = cy - m_h1;
        m_vx[1] = cx - m_half; m_vy[1] = cy + m_h2;
        m_vx[2] = cx + m_half; m_vy[2] = cy + m_h2;
        for (int i = 0; i < 3; i++)
            m_skip[i] = (m_vx[i] < 0) || (m_vx[i] > 255) || (m_vy[i] < 0) || (m_vy[i] > 255);
    endfunction

    function automatic bit model_win(input int n, input int x, input int y);
        case (n)
            0: return (y >= m_cy + m_h2) && (y <= m_cy - m_h1 + m_d);
            1: return (x >= m_cx) && (x <= m_cx + m_half) && (y >= m_cy - m_h1) && (y <= m_cy + m_h2);
            default: return (x >= m_cx - m_half) && (x <= m_cx) && (y >= m_cy - m_h1) && (y <= m_cy + m_h2);
        endcase
    endfunction

    // stop_arc >= 0 ends the run once that arc starts, by dropping start or by reset
    task automatic run_seq(input int cx, input int cy, input int d, input int col,
                           input int lat, input int stop_arc, input bit use_reset);
        int cnt;
        int base;
        model_setup(cx, cy, d);
        $display("run cx=%0d cy=%0d d=%0d colour=%0d lat=%0d skip=%0d%0d%0d stop=%0d",
                 cx, cy, d, col, lat, m_skip[0], m_skip[1], m_skip[2], stop_arc);
        centre_x = cx[7:0];
        centre_y = cy[7:0];
        diameter = d[7:0];
        colour   = col[2:0];
        arc_finished = 1'b0;
        arc_plot = 1'b0;
        start = 1'b1;
        tick();
        chk("done_clear", {31'd0, done}, 0);
        cnt  = 1;
        base = 3;
        for (int n = 0; n < 3; n++) begin
            if (m_skip[n]) begin
                base += 2;
                continue;
            end
            while (arc_start !== 1'b1 && cnt < base + 20) begin
                tick();
                cnt++;
            end
            chk("arc_start_lat", cnt, base);
            chk("centre_x", {24'd0, arc_centre_x}, m_vx[n]);
            chk("centre_y", {24'd0, arc_centre_y}, m_vy[n]);
            chk("radius", {24'd0, arc_radius}, d);
            chk("vga_colour", {29'd0, vga_colour}, col);
            if (n == stop_arc) begin
                arc_x = 8'd100;
                arc_y = 7'd50;
                arc_plot = 1'b1;
                if (use_reset) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_done", {31'd0, done}, 0);
                    chk("rst_arc_start", {31'd0, arc_start}, 0);
                    chk("rst_centre_x", {24'd0, arc_centre_x}, 0);
                    chk("rst_centre_y", {24'd0, arc_centre_y}, 0);
                    chk("rst_radius", {24'd0, arc_radius}, 0);
                    chk("rst_colour", {29'd0, vga_colour}, 0);
                    chk("rst_vga_plot", {31'd0, vga_plot}, 0);
                    start = 1'b0;
                    arc_plot = 1'b0;
                    tick();
                    rst_n = 1'b1;
                    tick();
                    chk("idle_after_reset", {31'd0, arc_start}, 0);
                end else begin
                    start = 1'b0;
                    tick();
                    chk("abort_arc_start", {31'd0, arc_start}, 0);
                    chk("abort_done", {31'd0, done}, 0);
                    chk("abort_vga_plot", {31'd0, vga_plot}, 0);
                    arc_plot = 1'b0;
                end
                return;
            end
            for (int c = 0; c < lat; c++) begin
                int px;
                int py;
                bit pl;
                bit exp_plot;
                string tg;
                if (dir_q.size() > 0 && dir_q[0].arc == n) begin
                    px = dir_q[0].x;
                    py = dir_q[0].y;
                    pl = 1'b1;
                    exp_plot = dir_q[0].exp;
                    tg = "win_directed";
                    void'(dir_q.pop_front());
                end else begin
                    px = clampi(m_cx - m_half - 2 + int'($urandom_range(0, m_d + 4)), 0, 255);
                    py = clampi(m_cy - m_h1 - 2 + int'($urandom_range(0, m_h1 + m_h2 + m_d + 4)), 0, 127);
                    pl = ($urandom_range(0, 3) != 0);
                    exp_plot = pl && model_win(n, px, py) && (px < 160) && (py < 120);
                    tg = "win_random";
                end
                arc_x = px[7:0];
                arc_y = py[6:0];
                arc_plot = pl;
                #1;
                chk(tg, {31'd0, vga_plot}, {31'd0, exp_plot});
                chk("vga_x", {24'd0, vga_x}, px);
                chk("vga_y", {25'd0, vga_y}, py);
                tick();
            end
            arc_plot = 1'b0;
            arc_finished = 1'b1;
            tick();
            arc_finished = 1'b0;
            tick();
            chk("arc_start_drop", {31'd0, arc_start}, 0);
            cnt  = 0;
            base = 1;
        end
        while (done !== 1'b1 && cnt < base + 20) begin
            tick();
            cnt++;
        end
        chk("done_lat", cnt, base);
    endtask

    task automatic end_seq();
        start = 1'b0;
        tick();
        tick();
        chk("done_fall", {31'd0, done}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        arc_x = 8'd80;
        arc_y = 7'd90;
        arc_plot = 1'b1;
        #1;
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_arc_start", {31'd0, arc_start}, 0);
        chk("reset_centre_x", {24'd0, arc_centre_x}, 0);
        chk("reset_radius", {24'd0, arc_radius}, 0);
        chk("reset_colour", {29'd0, vga_colour}, 0);
        chk("reset_vga_plot", {31'd0, vga_plot}, 0);
        arc_plot = 1'b0;
        rst_n = 1'b1;
        tick();

        // Nominal shape with window probes in ARC0 and ARC1
        dir_q.push_back('{0, 80, 94, 1'b1});
        dir_q.push_back('{0, 120, 83, 1'b1});
        dir_q.push_back('{0, 80, 13, 1'b0});
        dir_q.push_back('{1, 79, 50, 1'b0});
        dir_q.push_back('{1, 100, 50, 1'b1});
        run_seq(80, 60, 80, 3, 5, -1, 1'b0);
        chk("dir_probes_used", dir_q.size(), 0);

        // Restart: done holds while start stays high, lags one edge on release
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("done_hold", {31'd0, done}, 1);
        end
        start = 1'b0;
        tick();
        chk("done_lag", {31'd0, done}, 1);
        run_seq(80, 60, 80, 5, 5, -1, 1'b0);
        end_seq();

        // Skip: only the bottom-right vertex is on-screen-addressable
        run_seq(10, 10, 80, 6, 3, -1, 1'b0);
        end_seq();

        // Abort during ARC1
        run_seq(80, 60, 80, 2, 3, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_abort_done", {31'd0, done}, 0);
            chk("post_abort_start", {31'd0, arc_start}, 0);
        end

        // Reset during ARC1
        run_seq(80, 60, 80, 7, 3, 1, 1'b1);

        for (int r = 0; r < 25; r++) begin
            run_seq(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 4)), -1, 1'b0);
            end_seq();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/reuleaux_seq.md
# reuleaux_seq

- Upstream sequencer for the Reuleaux-triangle renderer.
- From a centre and diameter it computes the three triangle vertices and starts one circle-arc engine per vertex, in turn. Each arc uses that vertex as centre and the diameter as radius.
- It passes the engine's pixel stream through to the VGA adapter, but gates `vga_plot` so only the pixels on the wanted 60° arc are written.
- It sits between the top-level task FSM (start/done) and the shared arc engine (`arc_start`/`arc_finished`).

## Interface

- `SCREEN_W`, 160: visible width; plots with x ≥ SCREEN_W are suppressed.
- `SCREEN_H`, 120: visible height; plots with y ≥ SCREEN_H are suppressed.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level request; held high until `done`.
- `colour`  in  3  drawing colour; latched on leaving IDLE.
- `centre_x`, `centre_y`  in  8 each  Reuleaux centre; latched on leaving IDLE.
- `diameter`  in  8  side length; latched on leaving IDLE.
- `done`  out  1  high while in DONE.
- `arc_centre_x`, `arc_centre_y`  out  8 each  current vertex, registered.
- `arc_radius`  out  8  equals the latched diameter.
- `arc_start`  out  1  registered; high only in ARC0/1/2.
- `arc_finished`  in  1  engine completion flag.
- `arc_x`  in  8  engine pixel x.
- `arc_y`  in  7  engine pixel y.
- `arc_plot`  in  1  engine pixel strobe.
- `vga_x`, `vga_y`, `vga_colour`, `vga_plot`  out  8/7/3/1  to the VGA adapter.

## Operation

**Geometry.** Computed in CALC and registered in 10-bit signed arithmetic.
- h1 = (d·591)>>10 and h2 = (d·296)>>10.
- Vertices:
  - T = (cx, cy−h1)
  - BL = (cx−d/2, cy+h2)
  - BR = (cx+d/2, cy+h2)
- d/2 is `diameter>>1` (truncating).

**Windows.** All bounds are inclusive, compared as 10-bit signed.
- ARC0 (centre T): y ∈ [cy+h2, cy−h1+d].
- ARC1 (centre BL): x ∈ [cx, cx+d/2] and y ∈ [cy−h1, cy+h2].
- ARC2 (centre BR): x ∈ [cx−d/2, cx] and y ∈ [cy−h1, cy+h2].

**Skip rule.** If a vertex has a coordinate outside [0,255], that arc is skipped. Its ARC and GAP states each pass in one cycle with `arc_start`=0.

**FSM states.** IDLE, CALC, ARC0, GAP0, ARC1, GAP1, ARC2, GAP2, DONE.
- IDLE: on `start`=1, latch the inputs and go to CALC.
- CALC: one cycle, then go to ARC0.
- ARCn: hold `arc_start`=1; when `arc_finished`=1, go to GAPn.
- GAPn: hold `arc_start`=0; wait until `arc_finished`=0, then go to the next ARC (GAP2 goes to DONE).
- DONE: hold `done`=1 until `start`=0, then go to IDLE.

**Abort.** `start`=0 in any state other than IDLE/DONE forces IDLE on the next edge.
- `arc_start` and `done` are 0 from that edge.

**Pixel path.**
- `vga_x`=`arc_x` and `vga_y`=`arc_y`, combinational.
- `vga_colour` = the latched colour.
- `vga_plot` = `arc_plot` AND state∈ARCn AND pixel inside window n AND x<SCREEN_W AND y<SCREEN_H.

## Timing

**Reset.** State IDLE. All registered outputs are 0: `done`, `arc_start`, `arc_centre_x/y`, `arc_radius`, latched colour (so `vga_colour`=0). `vga_plot`=0.

**Latency.**
- `start` is sampled at edge k.
- CALC occupies cycle k+1.
- `arc_start`=1 and valid `arc_centre_*` appear after edge k+2.

**Pixel path timing.** Zero-cycle latency from engine to VGA; it is combinational only.

**Arc completion.**
- `arc_finished` seen high in ARCn at edge m gives `arc_start`=0 from edge m+1.
- GAPn lasts at least 1 cycle.
- `arc_finished`=1 in the first ARC cycle is honoured.

**Done handshake.**
- `done` rises on the edge after GAP2 exits.
- `done` falls on the edge after `start` is seen low.

**Reset mid-operation.** Immediate return to the reset values; there is no partial completion.

## Structure

**`reuleaux_pkg`** holds:
- the state enum;
- `SCREEN_W`/`SCREEN_H` defaults;
- the constants `K_H1=591`, `K_H2=296`, `K_SHIFT=10`;
- the 10-bit signed coordinate typedef.

**Sub-module `reuleaux_window`.** Purely combinational:
- Inputs: arc index, the latched cx/cy/d/h1/h2, and the pixel x/y.
- Output: `in_window`.

## Test plan

- **Reset.** Assert `rst_n`=0 mid-ARC1 → every output is 0 and the state is IDLE on the next cycle (before any clock edge).
- **Nominal sequence.** cx=80, cy=60, d=80, `start`=1, model engine returns `arc_finished` after 5 cycles each → three `arc_start` pulses with centres:
  - (80,14)
  - (40,83)
  - (120,83)
  - Radius is 80 throughout; `done`=1 two cycles after the third finish.
- **Window gating.** Same setup, in ARC0:
  - `arc_plot` at (80,94) → `vga_plot`=1.
  - (120,83) → 1.
  - (80,13) → 0.
  - In ARC1: (79,50) → 0 and (100,50) → 1.
- **Skip.** cx=10, cy=10, d=80 → T.y=−36 and BL.x=−30, so only ARC2 (centre 50,33) raises `arc_start`; `done` is still reached.
- **Abort.** `start` dropped during ARC1 → `arc_start`=0 at the next edge, state IDLE, `done` never asserted.
- **Restart.** `start` held after DONE → `done` stays 1. Drop `start` for 1 cycle, re-raise with new colour=3'b101 → a new full sequence runs and `vga_colour`=101.
